// File: rtl/seri2para_pkg.sv
// rtl/seri2para_pkg.sv - shared state type and width helpers for the row-stream deserialiser
package seri2para_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Counter width for an index running 0..n-1, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seri2para_row_asm.sv
// rtl/seri2para_row_asm.sv - column counter and pixel slice insertion for one row
module seri2para_row_asm
  import seri2para_pkg::*;
#(
  parameter int COLS      = 640,
  parameter int PIX_W     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  pix_fire_i,
  input  logic [PIX_W-1:0]      pix_i,
  input  logic                  hold_free_i,
  output logic                  row_done_o,
  output logic                  asm_full_o,
  output logic [COLS*PIX_W-1:0] row_word_o
);

  localparam int COL_W = idx_w(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [COL_W-1:0]      col_q;
  logic [COLS*PIX_W-1:0] row_q;
  logic                  asm_full_q;
  int                    slice_lo;

  // Row word including the pixel accepted this cycle, so a finished row can go straight to hold
  always_comb begin
    slice_lo   = 0;
    row_word_o = row_q;
    if (pix_fire_i) begin
      if (MSB_FIRST != 0) slice_lo = (COLS - 1 - int'(col_q)) * PIX_W;
      else                slice_lo = int'(col_q) * PIX_W;
      row_word_o[slice_lo +: PIX_W] = pix_i;
    end
  end

  assign row_done_o = pix_fire_i && (col_q == COL_LAST);
  assign asm_full_o = asm_full_q;

  // Column count, row storage, and the full flag that parks a row until hold frees
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      asm_full_q <= 1'b0;
    end else if (clear_i) begin
      col_q      <= '0;
      asm_full_q <= 1'b0;
    end else begin
      if (pix_fire_i) begin
        row_q <= row_word_o;
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      if (row_done_o && !hold_free_i)      asm_full_q <= 1'b1;
      else if (asm_full_q && hold_free_i)  asm_full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seri2para_rowstream.sv
// rtl/seri2para_rowstream.sv - pixel stream to per-row parallel words with a one-row hold buffer
module seri2para_rowstream
  import seri2para_pkg::*;
#(
  parameter int  COLS      = 640,
  parameter int  ROWS      = 480,
  parameter int  PIX_W     = 1,
  parameter int  MSB_FIRST = 1,
  parameter int  FCNT_W    = 16,
  localparam int ROW_W     = idx_w(ROWS)
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iSTART,
  input  logic                  iABORT,
  input  logic                  iPIX_VALID,
  input  logic [PIX_W-1:0]      iPIX,
  output logic                  oPIX_READY,
  output logic                  oROW_VALID,
  output logic [COLS*PIX_W-1:0] oROW_DATA,
  output logic [ROW_W-1:0]      oROW_IDX,
  input  logic                  iROW_READY,
  output logic                  oBUSY,
  output logic                  oFinished,
  output logic [FCNT_W-1:0]     oFRAME_CNT
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_e                state_q;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W-1:0]      pend_idx_q;
  logic [ROW_W-1:0]      hold_idx_q;
  logic [COLS*PIX_W-1:0] hold_q;
  logic                  hold_valid_q;
  logic                  finished_q;
  logic [FCNT_W-1:0]     fcnt_q;

  logic                  asm_full;
  logic                  row_done;
  logic [COLS*PIX_W-1:0] row_word;
  logic                  pix_fire;
  logic                  pop;
  logic                  hold_free;
  logic                  hold_load;
  logic                  start_go;
  logic                  asm_clear;
  logic [ROW_W-1:0]      hold_idx_d;

  assign oPIX_READY = (state_q == S_RUN) && !asm_full;
  assign pix_fire   = iPIX_VALID && oPIX_READY;
  assign pop        = hold_valid_q && iROW_READY;
  assign hold_free  = !hold_valid_q || pop;
  assign hold_load  = hold_free && (row_done || asm_full);
  assign start_go   = (state_q == S_IDLE) && iSTART && !iABORT;
  assign asm_clear  = iABORT || start_go;
  assign hold_idx_d = row_done ? row_q : pend_idx_q;

  seri2para_row_asm #(
    .COLS      (COLS),
    .PIX_W     (PIX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_row_asm (
    .clk_i       (iCLK),
    .rst_ni      (iRST_n),
    .clear_i     (asm_clear),
    .pix_fire_i  (pix_fire),
    .pix_i       (iPIX),
    .hold_free_i (hold_free),
    .row_done_o  (row_done),
    .asm_full_o  (asm_full),
    .row_word_o  (row_word)
  );

  // Frame FSM, row counter, hold buffer and frame bookkeeping; abort overrides everything
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      pend_idx_q   <= '0;
      hold_idx_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      finished_q   <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      finished_q <= 1'b0;
      if (iABORT) begin
        state_q      <= S_IDLE;
        row_q        <= '0;
        pend_idx_q   <= '0;
        hold_valid_q <= 1'b0;
      end else begin
        if (hold_load) begin
          hold_q       <= row_word;
          hold_idx_q   <= hold_idx_d;
          hold_valid_q <= 1'b1;
        end else if (pop) begin
          hold_valid_q <= 1'b0;
        end
        if (row_done && !hold_load) pend_idx_q <= row_q;
        case (state_q)
          S_IDLE: begin
            if (iSTART) begin
              state_q <= S_RUN;
              row_q   <= '0;
            end
          end
          S_RUN: begin
            if (row_done) begin
              if (row_q == ROW_LAST) begin
                row_q   <= '0;
                state_q <= S_DRAIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (pop && !asm_full) begin
              state_q    <= S_IDLE;
              finished_q <= 1'b1;
              fcnt_q     <= fcnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign oROW_VALID = hold_valid_q;
  assign oROW_DATA  = hold_q;
  assign oROW_IDX   = hold_idx_q;
  assign oBUSY      = (state_q != S_IDLE);
  assign oFinished  = finished_q;
  assign oFRAME_CNT = fcnt_q;

endmodule
